instruction_queue: RTL

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

---
 rtl/instruction_queue.sv | 96 +++++++++
 1 files changed

// File: rtl/instruction_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_queue : circular-buffer instruction FIFO that decodes the    |
// |   head entry into opcode / target_address fields.                        |
// | Optional macro INSTRUCTION_QUEUE_BYPASS_EN: empty-queue bypass path.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instruction_queue #(
   parameter int WIDTH    = 32,
   parameter int OPCODE_W = 6,
   parameter int DEPTH    = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_instr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OPCODE_W-1:0]       opcode,
   output logic [WIDTH-OPCODE_W-1:0] target_address,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic             w_empty;
   logic             w_full;
   logic             w_bypass;
   logic             w_bypass_take;
   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_head;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_full);

`ifdef INSTRUCTION_QUEUE_BYPASS_EN
   // An empty queue presents the incoming word directly to the consumer.
   assign w_bypass = w_empty && in_valid;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_bypass_take = w_bypass && out_ready;
   assign w_head        = w_bypass ? in_instr : r_mem[r_rd_ptr];

   assign in_ready  = !w_full;
   assign out_valid = !w_empty || w_bypass;
   assign count     = r_count;

   // A bypassed word is consumed without touching storage or the pointers.
   assign w_push = in_valid && in_ready && !w_bypass_take;
   assign w_pop  = !w_empty && out_ready;

   assign opcode         = out_valid ? w_head[WIDTH-1 -: OPCODE_W]       : '0;
   assign target_address = out_valid ? w_head[WIDTH-OPCODE_W-1:0]        : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush) begin
         // Storage contents are deliberately left intact on flush.
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_instr;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
